// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues one instruction-memory read at a time,
// holds the returned word in an instruction register for decode, and drives
// the program counter write port for sequential advance and branch redirect.
module instr_fetch #(
  parameter int unsigned PC_W    = 10,
  parameter int unsigned INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fetch_en,
  input  logic [PC_W-1:0]    pc_curr,
  input  logic [PC_W-1:0]    pc_inc,
  output logic               pc_we,
  output logic [PC_W-1:0]    pc_next,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               ir_valid,
  output logic [INSTR_W-1:0] ir_data,
  output logic [PC_W-1:0]    ir_pc,
  input  logic               ir_ready,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               busy
);

  // IDLE: no fetch in flight; REQ: read outstanding and wanted;
  // VALID: word held for decode; DRAIN: owed response will be thrown away.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    VALID = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;
  state_t resume;
  logic   capture;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, capture strobe and PC write port; redirect overrides last
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    pc_we     = 1'b0;
    pc_next   = '0;
    resume    = fetch_en ? REQ : IDLE;

    case (state)
      IDLE: begin
        // A response arriving here is stale and is ignored.
        if (!redirect && fetch_en) begin
          state_nxt = REQ;
        end
      end

      REQ: begin
        if (redirect) begin
          // With no response yet, the read is still owed: wait it out.
          state_nxt = imem_rvalid ? resume : DRAIN;
        end else if (imem_rvalid) begin
          capture   = 1'b1;
          pc_we     = 1'b1;
          pc_next   = pc_inc;
          state_nxt = VALID;
        end
      end

      VALID: begin
        // A redirect discards the held word even if decode takes it now.
        if (redirect || ir_ready) begin
          state_nxt = resume;
        end
      end

      DRAIN: begin
        // The owed response retires the drain even if a new redirect
        // lands in the same cycle; nothing else is outstanding afterwards.
        if (imem_rvalid) begin
          state_nxt = resume;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    if (redirect) begin
      pc_we   = 1'b1;
      pc_next = redirect_pc;
    end
  end

  // Memory request and status decode from the current state
  always_comb begin
    imem_req  = (state == REQ);
    imem_addr = (state == REQ) ? pc_curr : '0;
    busy      = (state != IDLE);
  end

  // Instruction register: valid flag tracks VALID, payload only on capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ir_valid <= 1'b0;
      ir_data  <= '0;
      ir_pc    <= '0;
    end else begin
      ir_valid <= (state_nxt == VALID);
      if (capture) begin
        ir_data <= imem_rdata;
        ir_pc   <= pc_curr;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: a directed cycle table, an async-reset sequence,
// and a randomized run against a word-level model of the fetched stream.
module tb_instr_fetch;

  localparam int unsigned PC_W    = 10;
  localparam int unsigned INSTR_W = 16;

  logic               clk;
  logic               rst;
  logic               fetch_en;
  logic [PC_W-1:0]    pc_curr;
  logic [PC_W-1:0]    pc_inc;
  logic               pc_we;
  logic [PC_W-1:0]    pc_next;
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;
  logic               ir_valid;
  logic [INSTR_W-1:0] ir_data;
  logic [PC_W-1:0]    ir_pc;
  logic               ir_ready;
  logic               redirect;
  logic [PC_W-1:0]    redirect_pc;
  logic               busy;

  instr_fetch #(.PC_W(PC_W), .INSTR_W(INSTR_W)) dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en),
    .pc_curr(pc_curr), .pc_inc(pc_inc),
    .pc_we(pc_we), .pc_next(pc_next),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .ir_valid(ir_valid), .ir_data(ir_data), .ir_pc(ir_pc),
    .ir_ready(ir_ready), .redirect(redirect), .redirect_pc(redirect_pc),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic                fe;
    logic                rv;
    logic [INSTR_W-1:0]  rd;
    logic                rdy;
    logic                redir;
    logic [PC_W-1:0]     rpc;
    logic                req;
    logic [PC_W-1:0]     addr;
    logic                we;
    logic [PC_W-1:0]     nxt;
    logic                irv;
    logic [INSTR_W-1:0]  ird;
    logic [PC_W-1:0]     irpc;
    logic                bsy;
  } vec_t;

  int unsigned vectors;
  int unsigned miscompares;

  // Program counter register kept by the bench, written from pc_we/pc_next
  logic [PC_W-1:0]    pc_reg;
  logic               pend_we;
  logic [PC_W-1:0]    pend_next;
  logic [INSTR_W-1:0] mem [1024];

  function automatic vec_t mk(input logic fe, input logic rv, input logic [15:0] rd,
                              input logic rdy, input logic redir, input logic [9:0] rpc,
                              input logic req, input logic [9:0] addr, input logic we,
                              input logic [9:0] nxt, input logic irv, input logic [15:0] ird,
                              input logic [9:0] irpc, input logic bsy);
    vec_t v;
    v.fe = fe; v.rv = rv; v.rd = rd; v.rdy = rdy; v.redir = redir; v.rpc = rpc;
    v.req = req; v.addr = addr; v.we = we; v.nxt = nxt;
    v.irv = irv; v.ird = ird; v.irpc = irpc; v.bsy = bsy;
    return v;
  endfunction

  task automatic check(input string name, input bit ok, input string detail);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  // Called just after a falling edge: commit last cycle's PC write, drive inputs
  task automatic apply(input logic fe, input logic rv, input logic [15:0] rd,
                       input logic rdy, input logic redir, input logic [9:0] rpc);
    if (pend_we) pc_reg = pend_next;
    pend_we     = 1'b0;
    pc_curr     = pc_reg;
    pc_inc      = PC_W'(pc_reg + 10'd1);
    fetch_en    = fe;
    imem_rvalid = rv;
    imem_rdata  = rd;
    ir_ready    = rdy;
    redirect    = redir;
    redirect_pc = rpc;
    #1;
    pend_we   = pc_we;
    pend_next = pc_next;
  endtask

  function automatic string act_str();
    return $sformatf("got req=%0b addr=%h we=%0b next=%h irv=%0b ird=%h irpc=%h busy=%0b",
                     imem_req, imem_addr, pc_we, pc_next, ir_valid, ir_data, ir_pc, busy);
  endfunction

  vec_t tbl [30];

  initial begin
    vectors     = 0;
    miscompares = 0;
    pc_reg      = '0;
    pend_we     = 1'b0;
    pend_next   = '0;
    rst         = 1'b0;
    fetch_en    = 1'b0;
    pc_curr     = '0;
    pc_inc      = 10'd1;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    ir_ready    = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;

    //           fe rv rd       rdy rd rpc      req addr    we nxt     irv ird       irpc    busy
    tbl[0]  = mk(1, 0, 16'h0,    0, 0, 10'h0,   0, 10'h0,   0, 10'h0,   0, 16'h0,    10'h0,   0);
    tbl[1]  = mk(1, 0, 16'h0,    0, 0, 10'h0,   1, 10'h0,   0, 10'h0,   0, 16'h0,    10'h0,   1);
    tbl[2]  = mk(1, 1, 16'hA001, 0, 0, 10'h0,   1, 10'h0,   1, 10'h001, 0, 16'h0,    10'h0,   1);
    tbl[3]  = mk(1, 0, 16'h0,    0, 0, 10'h0,   0, 10'h0,   0, 10'h0,   1, 16'hA001, 10'h0,   1);
    tbl[4]  = mk(1, 0, 16'h0,    0, 0, 10'h0,   0, 10'h0,   0, 10'h0,   1, 16'hA001, 10'h0,   1);
    tbl[5]  = mk(1, 0, 16'h0,    0, 0, 10'h0,   0, 10'h0,   0, 10'h0,   1, 16'hA001, 10'h0,   1);
    tbl[6]  = mk(1, 0, 16'h0,    0, 0, 10'h0,   0, 10'h0,   0, 10'h0,   1, 16'hA001, 10'h0,   1);
    tbl[7]  = mk(1, 0, 16'h0,    0, 0, 10'h0,   0, 10'h0,   0, 10'h0,   1, 16'hA001, 10'h0,   1);
    tbl[8]  = mk(1, 0, 16'h0,    1, 0, 10'h0,   0, 10'h0,   0, 10'h0,   1, 16'hA001, 10'h0,   1);
    tbl[9]  = mk(1, 0, 16'h0,    0, 0, 10'h0,   1, 10'h001, 0, 10'h0,   0, 16'hA001, 10'h0,   1);
    tbl[10] = mk(1, 1, 16'hB002, 0, 0, 10'h0,   1, 10'h001, 1, 10'h002, 0, 16'hA001, 10'h0,   1);
    tbl[11] = mk(1, 0, 16'h0,    1, 1, 10'h040, 0, 10'h0,   1, 10'h040, 1, 16'hB002, 10'h001, 1);
    tbl[12] = mk(1, 0, 16'h0,    0, 0, 10'h0,   1, 10'h040, 0, 10'h0,   0, 16'hB002, 10'h001, 1);
    tbl[13] = mk(1, 0, 16'h0,    0, 1, 10'h080, 1, 10'h040, 1, 10'h080, 0, 16'hB002, 10'h001, 1);
    tbl[14] = mk(1, 0, 16'h0,    0, 0, 10'h0,   0, 10'h0,   0, 10'h0,   0, 16'hB002, 10'h001, 1);
    tbl[15] = mk(1, 1, 16'hDEAD, 0, 0, 10'h0,   0, 10'h0,   0, 10'h0,   0, 16'hB002, 10'h001, 1);
    tbl[16] = mk(1, 0, 16'h0,    0, 0, 10'h0,   1, 10'h080, 0, 10'h0,   0, 16'hB002, 10'h001, 1);
    tbl[17] = mk(1, 1, 16'hC003, 0, 1, 10'h3FF, 1, 10'h080, 1, 10'h3FF, 0, 16'hB002, 10'h001, 1);
    tbl[18] = mk(1, 0, 16'h0,    0, 0, 10'h0,   1, 10'h3FF, 0, 10'h0,   0, 16'hB002, 10'h001, 1);
    tbl[19] = mk(1, 1, 16'hE004, 0, 0, 10'h0,   1, 10'h3FF, 1, 10'h000, 0, 16'hB002, 10'h001, 1);
    tbl[20] = mk(0, 0, 16'h0,    1, 0, 10'h0,   0, 10'h0,   0, 10'h0,   1, 16'hE004, 10'h3FF, 1);
    tbl[21] = mk(0, 0, 16'h0,    0, 0, 10'h0,   0, 10'h0,   0, 10'h0,   0, 16'hE004, 10'h3FF, 0);
    tbl[22] = mk(0, 0, 16'h0,    0, 1, 10'h123, 0, 10'h0,   1, 10'h123, 0, 16'hE004, 10'h3FF, 0);
    tbl[23] = mk(0, 0, 16'h0,    0, 0, 10'h0,   0, 10'h0,   0, 10'h0,   0, 16'hE004, 10'h3FF, 0);
    tbl[24] = mk(1, 0, 16'h0,    0, 0, 10'h0,   0, 10'h0,   0, 10'h0,   0, 16'hE004, 10'h3FF, 0);
    tbl[25] = mk(0, 0, 16'h0,    0, 0, 10'h0,   1, 10'h123, 0, 10'h0,   0, 16'hE004, 10'h3FF, 1);
    tbl[26] = mk(0, 1, 16'h5A5A, 0, 0, 10'h0,   1, 10'h123, 1, 10'h124, 0, 16'hE004, 10'h3FF, 1);
    tbl[27] = mk(0, 0, 16'h0,    0, 0, 10'h0,   0, 10'h0,   0, 10'h0,   1, 16'h5A5A, 10'h123, 1);
    tbl[28] = mk(0, 0, 16'h0,    1, 0, 10'h0,   0, 10'h0,   0, 10'h0,   1, 16'h5A5A, 10'h123, 1);
    tbl[29] = mk(0, 0, 16'h0,    0, 0, 10'h0,   0, 10'h0,   0, 10'h0,   0, 16'h5A5A, 10'h123, 0);

    // Reset state
    #1;
    check("reset_state",
          !imem_req && imem_addr == '0 && !pc_we && !ir_valid && ir_data == '0 && ir_pc == '0 && !busy,
          act_str());
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Directed cycle table
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      apply(tbl[i].fe, tbl[i].rv, tbl[i].rd, tbl[i].rdy, tbl[i].redir, tbl[i].rpc);
      check($sformatf("table[%0d]", i),
            imem_req == tbl[i].req && imem_addr == tbl[i].addr && pc_we == tbl[i].we &&
            (!tbl[i].we || pc_next == tbl[i].nxt) && ir_valid == tbl[i].irv &&
            ir_data == tbl[i].ird && ir_pc == tbl[i].irpc && busy == tbl[i].bsy,
            $sformatf("%s want req=%0b addr=%h we=%0b next=%h irv=%0b ird=%h irpc=%h busy=%0b",
                      act_str(), tbl[i].req, tbl[i].addr, tbl[i].we, tbl[i].nxt,
                      tbl[i].irv, tbl[i].ird, tbl[i].irpc, tbl[i].bsy));
    end

    // Asynchronous reset in the middle of a fetch, then a stale response
    @(negedge clk);
    apply(1, 0, 16'h0, 0, 0, 10'h0);
    @(negedge clk);
    apply(0, 0, 16'h0, 0, 0, 10'h0);
    check("areset_pre_req", imem_req && busy && imem_addr == 10'h124, act_str());
    #2;
    rst = 1'b0;
    #1;
    check("areset_immediate",
          !imem_req && imem_addr == '0 && !busy && !ir_valid && ir_data == '0 && ir_pc == '0 && !pc_we,
          act_str());
    @(negedge clk);
    rst = 1'b1;
    apply(0, 1, 16'hFFFF, 0, 0, 10'h0);
    check("stale_rvalid_cycle", !imem_req && !busy && !pc_we && !ir_valid, act_str());
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      apply(0, 0, 16'h0, 1, 0, 10'h0);
      check($sformatf("post_reset_idle[%0d]", i),
            !imem_req && !busy && !pc_we && !ir_valid && ir_data == '0 && ir_pc == '0, act_str());
    end

    // Randomized run against a model of the expected instruction stream
    begin
      logic               outstanding;
      int unsigned        cnt;
      logic [PC_W-1:0]    maddr;
      logic [PC_W-1:0]    exp_pc;
      logic               prev_hold;
      logic [INSTR_W-1:0] prev_data;
      logic [PC_W-1:0]    prev_pc;
      int unsigned        accepted;
      logic               fe, rv, rdy, redir, newreq;
      logic [INSTR_W-1:0] rd;
      logic [PC_W-1:0]    rpc;

      for (int i = 0; i < 1024; i++) mem[i] = INSTR_W'($urandom);
      outstanding = 1'b0;
      cnt         = 0;
      maddr       = '0;
      exp_pc      = pc_reg;
      prev_hold   = 1'b0;
      prev_data   = '0;
      prev_pc     = '0;
      accepted    = 0;

      for (int cyc = 0; cyc < 3000; cyc++) begin
        @(negedge clk);
        rv     = 1'b0;
        rd     = '0;
        newreq = 1'b0;
        if (outstanding) begin
          if (cnt == 0) begin
            rv          = 1'b1;
            rd          = mem[maddr];
            outstanding = 1'b0;
          end else begin
            cnt--;
          end
        end else if (imem_req) begin
          newreq      = 1'b1;
          outstanding = 1'b1;
          cnt         = $urandom_range(3, 0);
        end
        fe    = ($urandom_range(7, 0) != 0);
        rdy   = ($urandom_range(2, 0) != 0);
        redir = ($urandom_range(9, 0) == 0) && !rv;
        rpc   = PC_W'($urandom);
        apply(fe, rv, rd, rdy, redir, rpc);

        if (newreq) begin
          maddr = imem_addr;
          check("req_addr_is_pc", imem_addr == pc_reg,
                $sformatf("addr=%h pc=%h", imem_addr, pc_reg));
        end else if (imem_req) begin
          check("req_addr_stable", outstanding || rv ? imem_addr == maddr : 1'b0,
                $sformatf("addr=%h issued=%h outstanding=%0b", imem_addr, maddr, outstanding));
        end

        if (redir) begin
          check("redirect_write", pc_we && pc_next == rpc,
                $sformatf("we=%0b next=%h want %h", pc_we, pc_next, rpc));
          exp_pc = rpc;
        end else if (pc_we) begin
          check("seq_write", rv && pc_next == PC_W'(pc_reg + 10'd1),
                $sformatf("rvalid=%0b next=%h want %h", rv, pc_next, PC_W'(pc_reg + 10'd1)));
        end

        if (prev_hold) begin
          check("ir_hold", ir_valid && ir_data == prev_data && ir_pc == prev_pc,
                $sformatf("irv=%0b ird=%h irpc=%h want %h/%h", ir_valid, ir_data, ir_pc,
                          prev_data, prev_pc));
        end

        if (ir_valid && rdy && !redir) begin
          check("accept_word", ir_pc == exp_pc && ir_data == mem[ir_pc],
                $sformatf("irpc=%h want %h ird=%h want %h", ir_pc, exp_pc, ir_data, mem[exp_pc]));
          exp_pc = PC_W'(ir_pc + 10'd1);
          accepted++;
        end

        if (!busy || ir_valid) begin
          check("status_consistency", !imem_req && (busy || !ir_valid),
                $sformatf("busy=%0b req=%0b irv=%0b", busy, imem_req, ir_valid));
        end

        prev_hold = ir_valid && !rdy && !redir;
        prev_data = ir_data;
        prev_pc   = ir_pc;
      end

      check("forward_progress", accepted >= 100,
            $sformatf("accepted=%0d want >= 100", accepted));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
